// File: rtl/inpdt_mac.sv
// inpdt_mac
//   Streams four lanes of quantized unsigned bytes (weights and data) per
//   beat, strips both zero points, and accumulates the signed inner product
//   sum((w-ZERO_W)*(x-ZERO_DATA)) over vec_len beats. The saturated 32-bit
//   result is held on inpdt_R_reg under a valid/ready handshake for the
//   downstream bias/requantize stage.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : one-cycle pulse, honoured only in IDLE
//   vec_len      : beats to accumulate, sampled on an accepted start
//   w_data       : four packed weight bytes, lane0 = [7:0]
//   x_data       : four packed data bytes, lane0 = [7:0]
//   in_valid     : input beat valid
//   in_ready     : block accepts a beat (ACC only)
//   inpdt_R_reg  : signed accumulated inner product
//   out_valid    : inpdt_R_reg holds a final result (DONE)
//   out_ready    : downstream consumes the result
//   busy         : high in ACC or DONE
//   sat_flag     : the current or last result saturated
module inpdt_mac #(
  parameter logic [7:0] ZERO_W    = 8'd128,
  parameter logic [7:0] ZERO_DATA = 8'd128,
  parameter int unsigned LANES    = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [31:0]      w_data,
  input  logic [31:0]      x_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      inpdt_R_reg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [31:0]        acc, acc_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic [31:0]        res_n;
  logic               sat_n;

  logic signed [8:0]  dw [LANES];
  logic signed [8:0]  dx [LANES];
  logic signed [17:0] prod [LANES];
  logic signed [19:0] beat_sum;
  logic signed [32:0] acc_wide;
  logic [31:0]        acc_sat;
  logic               ovf;

  // Per-lane zero-point removal and products, summed into one beat value.
  always_comb begin
    beat_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dw[i]    = $signed({1'b0, w_data[8*i +: 8]}) - $signed({1'b0, ZERO_W});
      dx[i]    = $signed({1'b0, x_data[8*i +: 8]}) - $signed({1'b0, ZERO_DATA});
      prod[i]  = 18'(dw[i]) * 18'(dx[i]);
      beat_sum = beat_sum + 20'(prod[i]);
    end
  end

  // 33-bit add; the top two bits disagreeing means the 32-bit range was left,
  // and bit 32 gives the true sign of the overflowed sum.
  always_comb begin
    acc_wide = $signed({acc[31], acc}) + 33'(beat_sum);
    ovf      = acc_wide[32] ^ acc_wide[31];
    if (!ovf) begin
      acc_sat = acc_wide[31:0];
    end else if (acc_wide[32]) begin
      acc_sat = 32'h8000_0000;
    end else begin
      acc_sat = 32'h7FFF_FFFF;
    end
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    remaining_n = remaining;
    res_n       = inpdt_R_reg;
    sat_n       = sat_flag;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_n = '0;
          sat_n = 1'b0;
          if (vec_len != '0) begin
            remaining_n = vec_len;
            state_n     = ACC;
          end else begin
            res_n   = '0;
            state_n = DONE;
          end
        end
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          acc_n       = acc_sat;
          remaining_n = remaining - LEN_W'(1);
          if (ovf) begin
            sat_n = 1'b1;
          end
          if (remaining == LEN_W'(1)) begin
            res_n   = acc_sat;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      remaining   <= '0;
      inpdt_R_reg <= '0;
      sat_flag    <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      remaining   <= remaining_n;
      inpdt_R_reg <= res_n;
      sat_flag    <= sat_n;
    end
  end

endmodule

// File: tb/tb_inpdt_mac.sv
module tb_inpdt_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] vec_len;
  logic [31:0] w_data;
  logic [31:0] x_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inpdt_R_reg;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        sat_flag;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] r;
    logic        s;
  } exp_t;

  exp_t   sb[$];
  longint model_acc;
  logic   model_sat;

  always #5 clk = ~clk;

  inpdt_mac #(
    .ZERO_W(8'd128),
    .ZERO_DATA(8'd128),
    .LANES(4),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vec_len(vec_len),
    .w_data(w_data),
    .x_data(x_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .inpdt_R_reg(inpdt_R_reg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .sat_flag(sat_flag)
  );

  function automatic longint model_beat(logic [31:0] w, logic [31:0] x);
    longint s = 0;
    for (int i = 0; i < 4; i++) begin
      s += (longint'(w[8*i +: 8]) - 128) * (longint'(x[8*i +: 8]) - 128);
    end
    return s;
  endfunction

  task automatic start_vec(input logic [15:0] len);
    @(negedge clk);
    start   = 1'b1;
    vec_len = len;
    @(posedge clk);
    #1;
    start     = 1'b0;
    model_acc = 0;
    model_sat = 1'b0;
    if (len == 0) sb.push_back('{32'h0, 1'b0});
  endtask

  // Drives one beat, waiting (bounded) for in_ready; last marks the final beat.
  task automatic send_beat(input logic [31:0] w, input logic [31:0] x, input bit last);
    int wait_cyc = 0;
    @(negedge clk);
    while (!in_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    checks++;
    w_data   = w;
    x_data   = x;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    model_acc = model_acc + model_beat(w, x);
    if (model_acc > 64'sh7FFF_FFFF) begin
      model_acc = 64'sh7FFF_FFFF;
      model_sat = 1'b1;
    end else if (model_acc < -64'sh8000_0000) begin
      model_acc = -64'sh8000_0000;
      model_sat = 1'b1;
    end
    if (last) sb.push_back('{model_acc[31:0], model_sat});
  endtask

  // Waits (bounded) for out_valid, compares against the scoreboard, consumes.
  task automatic collect(input string name);
    exp_t e;
    int   wait_cyc = 0;
    while (!out_valid && wait_cyc < 20) begin
      @(posedge clk);
      #1;
      wait_cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_out_valid: got %b required 1", name, out_valid);
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard_empty: got 0 entries required 1", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (inpdt_R_reg !== e.r) begin
        errors++;
        $display("FAIL %s_result: got %h required %h", name, inpdt_R_reg, e.r);
      end
      checks++;
      if (sat_flag !== e.s) begin
        errors++;
        $display("FAIL %s_sat: got %b required %b", name, sat_flag, e.s);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_consume: out_valid=%b busy=%b required 0 0", name, out_valid, busy);
    end
  endtask

  task automatic check_ov(input string name, input logic req);
    checks++;
    if (out_valid !== req) begin
      errors++;
      $display("FAIL %s: out_valid got %b required %b", name, out_valid, req);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0; vec_len = '0; w_data = '0; x_data = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, sat_flag} !== 4'b0000 || inpdt_R_reg !== 32'h0) begin
      errors++;
      $display("FAIL reset: rdy/ov/busy/sat=%b R=%h required 0000 00000000",
               {in_ready, out_valid, busy, sat_flag}, inpdt_R_reg);
    end
  endtask

  task automatic test_single;
    start_vec(16'd1);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_acc_state: in_ready=%b busy=%b required 1 1", in_ready, busy);
    end
    send_beat(32'h81818181, 32'h82828282, 1'b1);
    check_ov("single_latency", 1'b1);
    checks++;
    if (sb.size() != 0 && sb[0].r !== 32'd8) begin
      errors++;
      $display("FAIL single_model: got %0d required 8", sb[0].r);
    end
    collect("single");
  endtask

  task automatic test_gaps;
    start_vec(16'd3);
    for (int b = 0; b < 3; b++) begin
      send_beat(32'h0, 32'h0, b == 2);
      check_ov($sformatf("gaps_ov_beat%0d", b), b == 2);
      if (b < 2) repeat (2) @(posedge clk);
    end
    collect("gaps");
  endtask

  task automatic test_negative_backpressure;
    logic [31:0] held;
    start_vec(16'd2);
    send_beat(32'h0, 32'hFFFFFFFF, 1'b0);
    send_beat(32'h0, 32'hFFFFFFFF, 1'b1);
    held = inpdt_R_reg;
    checks++;
    if (held !== 32'hFFFE0400) begin
      errors++;
      $display("FAIL neg_value: got %h required fffe0400", held);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || inpdt_R_reg !== held) begin
        errors++;
        $display("FAIL neg_hold_c%0d: ov=%b R=%h required 1 %h", c, out_valid, inpdt_R_reg, held);
      end
    end
    collect("negative");
  endtask

  task automatic test_saturation;
    start_vec(16'd32768);
    for (int b = 0; b < 32768; b++) begin
      send_beat(32'h0, 32'h0, b == 32767);
    end
    check_ov("sat_latency", 1'b1);
    collect("saturation");
  endtask

  task automatic test_zero_len;
    start_vec(16'd0);
    check_ov("zero_len_latency", 1'b1);
    collect("zero_len");
  endtask

  task automatic test_start_in_acc;
    start_vec(16'd3);
    send_beat(32'h81818181, 32'h82828282, 1'b0);
    @(negedge clk);
    start   = 1'b1;
    vec_len = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_beat(32'h7F7F7F7F, 32'h90909090, 1'b0);
    check_ov("start_in_acc_mid", 1'b0);
    send_beat(32'h10203040, 32'hF0E0D0C0, 1'b1);
    check_ov("start_in_acc_end", 1'b1);
    collect("start_in_acc");
  endtask

  task automatic test_reset_mid;
    start_vec(16'd4);
    send_beat(32'h0, 32'h0, 1'b0);
    send_beat(32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000 || inpdt_R_reg !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: rdy/ov/busy=%b R=%h required 000 00000000",
               {in_ready, out_valid, busy}, inpdt_R_reg);
    end
    repeat (2) @(posedge clk);
    #1;
    check_ov("reset_mid_no_partial", 1'b0);
    start_vec(16'd1);
    send_beat(32'h81818181, 32'h82828282, 1'b1);
    collect("after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_negative_backpressure();
    test_zero_len();
    test_start_in_acc();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
